// File: rtl/pattern_render_engine_pkg.sv
// Shared types for the pattern render engine: screen coordinates, fp4.4 samples,
// pattern modes and the frame FSM states.
package pattern_render_engine_pkg;

  localparam int unsigned CoordW   = 10;
  localparam int unsigned LutAddrW = 6;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } screen_xy_t;

  // Signed fixed point, 4 integer and 4 fraction bits: 1.0 == 16.
  typedef logic signed [7:0] fp44_t;

  typedef enum logic [3:0] {
    ModeBlank    = 4'd0,
    ModeDiag     = 4'd1,
    ModeTop      = 4'd2,
    ModeHalfDiag = 4'd3,
    ModeMid      = 4'd4,
    ModeSteep    = 4'd5,
    ModeBars     = 4'd6,
    ModeSine     = 4'd7,
    ModeSolid    = 4'd8,
    ModeChecker  = 4'd9
  } render_mode_e;

  typedef enum logic [1:0] {StIdle, StRender, StDrain} render_state_e;

endpackage

// File: rtl/pattern_render_engine_if.sv
// Frame control and pixel stream bundle between the render engine and its host/sink.
interface pattern_render_engine_if
  import pattern_render_engine_pkg::*;
#(
  parameter int unsigned COLOR_W = 3
) ();
  logic [3:0]         mode;
  logic [COLOR_W-1:0] fg_color;
  logic [COLOR_W-1:0] bg_color;
  logic               render_ack;
  logic               render_done;
  logic               pix_valid;
  logic               pix_ready;
  screen_xy_t         coords_out;
  logic [COLOR_W-1:0] color_out;
  logic               busy;
  logic [15:0]        frame_count;

  modport master (
    input  mode, fg_color, bg_color, render_ack, pix_ready,
    output render_done, pix_valid, coords_out, color_out, busy, frame_count
  );

  modport slave (
    output mode, fg_color, bg_color, render_ack, pix_ready,
    input  render_done, pix_valid, coords_out, color_out, busy, frame_count
  );
endinterface

// File: rtl/pattern_render_engine_trig_lut.sv
// Registered sine lookup: 64 entries per period in fp4.4, built from a quarter-wave table.
module pattern_render_engine_trig_lut
  import pattern_render_engine_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                en,
  input  logic [LutAddrW-1:0] addr,
  output fp44_t               data
);

  function automatic logic [4:0] quarter_sin(input logic [4:0] idx);
    case (idx)
      5'd0:  quarter_sin = 5'd0;
      5'd1:  quarter_sin = 5'd2;
      5'd2:  quarter_sin = 5'd3;
      5'd3:  quarter_sin = 5'd5;
      5'd4:  quarter_sin = 5'd6;
      5'd5:  quarter_sin = 5'd8;
      5'd6:  quarter_sin = 5'd9;
      5'd7:  quarter_sin = 5'd10;
      5'd8:  quarter_sin = 5'd11;
      5'd9:  quarter_sin = 5'd12;
      5'd10: quarter_sin = 5'd13;
      5'd11: quarter_sin = 5'd14;
      5'd12: quarter_sin = 5'd15;
      5'd13: quarter_sin = 5'd15;
      5'd14: quarter_sin = 5'd16;
      5'd15: quarter_sin = 5'd16;
      5'd16: quarter_sin = 5'd16;
      default: quarter_sin = 5'd0;
    endcase
  endfunction

  logic [4:0] idx;
  logic [7:0] mag;
  fp44_t      value;

  // addr[4] mirrors the quarter, addr[5] negates the half period.
  always_comb begin
    idx   = addr[4] ? 5'd16 - {1'b0, addr[3:0]} : {1'b0, addr[3:0]};
    mag   = {3'b000, quarter_sin(idx)};
    value = addr[5] ? 8'd0 - mag : mag;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data <= '0;
    end else if (en) begin
      data <= value;
    end
  end

endmodule

// File: rtl/pattern_render_engine.sv
// Raster-scan test-pattern generator: issue counter -> LUT/coords stage -> output register,
// emitting one pixel beat per cycle on a valid/ready stream.
module pattern_render_engine
  import pattern_render_engine_pkg::*;
#(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned LUT_STEP    = 16,
  parameter int unsigned CHECK_SHIFT = 3
) (
  input logic                     Clk,
  input logic                     Reset_n,
  pattern_render_engine_if.master bus
);

  localparam logic [CoordW-1:0] XLast = CoordW'(WIDTH - 1);
  localparam logic [CoordW-1:0] YLast = CoordW'(HEIGHT - 1);

  function automatic logic pattern_hit(input logic [3:0] m, input screen_xy_t p, input fp44_t s);
    logic [CoordW-1:0] chk;
    int                row;
    chk = (p.x >> CHECK_SHIFT) ^ (p.y >> CHECK_SHIFT);
    row = ((int'(s) + 16) * int'(HEIGHT / 2)) / 16;
    if (row > int'(HEIGHT) - 1) row = int'(HEIGHT) - 1;
    case (m)
      ModeDiag:     pattern_hit = (p.x == p.y);
      ModeTop:      pattern_hit = (p.y == '0);
      ModeHalfDiag: pattern_hit = ((p.x >> 1) == p.y);
      ModeMid:      pattern_hit = (p.y == CoordW'(HEIGHT / 2));
      ModeSteep:    pattern_hit = (p.x == (p.y >> 1));
      ModeBars:     pattern_hit = p.x[3];
      ModeSine:     pattern_hit = (int'(p.y) == row);
      ModeSolid:    pattern_hit = 1'b1;
      ModeChecker:  pattern_hit = chk[0];
      default:      pattern_hit = 1'b0;
    endcase
  endfunction

  render_state_e       state_q, state_d;
  logic [CoordW-1:0]   x_q, x_d, y_q, y_d;
  logic [3:0]          mode_q;
  logic [COLOR_W-1:0]  fg_q, bg_q;
  logic                s1_valid_q;
  screen_xy_t          s1_xy_q;
  logic                pix_valid_q;
  screen_xy_t          coords_q;
  logic [COLOR_W-1:0]  color_q;
  logic                done_q;
  logic [15:0]         frame_count_q;
  fp44_t               lut_data;
  logic [LutAddrW-1:0] lut_addr;
  logic                adv, start, accept_last;

  assign adv = !pix_valid_q || bus.pix_ready;
  // The done-pulse cycle is already IDLE but must not restart the frame.
  assign start = (state_q == StIdle) && bus.render_ack && !done_q;
  assign accept_last = (state_q == StDrain) && pix_valid_q && bus.pix_ready &&
                       (coords_q.x == XLast) && (coords_q.y == YLast);
  assign lut_addr = LutAddrW'(x_q * LUT_STEP);

  pattern_render_engine_trig_lut u_lut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      (adv),
    .addr    (lut_addr),
    .data    (lut_data)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRender;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StRender: begin
        if (adv) begin
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              y_d     = '0;
              state_d = StDrain;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (accept_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      mode_q        <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      s1_valid_q    <= 1'b0;
      s1_xy_q       <= '0;
      pix_valid_q   <= 1'b0;
      coords_q      <= '0;
      color_q       <= '0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= accept_last;
      if (accept_last) frame_count_q <= frame_count_q + 16'd1;
      if (start) begin
        mode_q <= bus.mode;
        fg_q   <= bus.fg_color;
        bg_q   <= bus.bg_color;
      end
      if (adv) begin
        s1_valid_q  <= (state_q == StRender);
        s1_xy_q     <= '{x: x_q, y: y_q};
        pix_valid_q <= s1_valid_q;
        coords_q    <= s1_xy_q;
        color_q     <= pattern_hit(mode_q, s1_xy_q, lut_data) ? fg_q : bg_q;
      end
    end
  end

  assign bus.render_done = done_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.coords_out  = coords_q;
  assign bus.color_out   = color_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_pattern_render_engine.sv
// Directed bench: pattern vectors on an 8x4 engine plus a sine-column check on a 16x240 engine.
module tb_pattern_render_engine;
  import pattern_render_engine_pkg::*;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int Pix = W * H;
  localparam int SW  = 16;
  localparam int SH  = 240;

  typedef struct {
    logic [3:0] mode;
    logic [2:0] fg;
    logic [2:0] bg;
    int         x;
    int         y;
    logic [2:0] exp;
  } vec_t;

  logic Clk;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] frame_col [Pix];
  vec_t vecs[$];

  pattern_render_engine_if #(.COLOR_W(3)) bus ();
  pattern_render_engine_if #(.COLOR_W(3)) sb ();

  pattern_render_engine #(
    .WIDTH(W), .HEIGHT(H), .COLOR_W(3), .LUT_STEP(16), .CHECK_SHIFT(1)
  ) u_dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  pattern_render_engine #(
    .WIDTH(SW), .HEIGHT(SH), .COLOR_W(3), .LUT_STEP(16), .CHECK_SHIFT(3)
  ) u_sine (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (sb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, bus.render_done, 0);
    check({tag, "_valid"}, bus.pix_valid, 0);
    check({tag, "_coords"}, bus.coords_out, 0);
    check({tag, "_color"}, bus.color_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_fcount"}, bus.frame_count, 0);
  endtask

  function automatic void add(input logic [3:0] m, input logic [2:0] fg, input logic [2:0] bg,
                              input int x, input int y, input logic [2:0] e);
    vecs.push_back('{mode: m, fg: fg, bg: bg, x: x, y: y, exp: e});
  endfunction

  // Runs one frame on u_dut from IDLE, capturing colors in beat order into frame_col.
  task automatic run_frame(input logic [3:0] m, input logic [2:0] fg, input logic [2:0] bg,
                           input bit stall, input bit hold, input logic [3:0] m2,
                           input logic [2:0] fg2, input logic [2:0] bg2);
    int n = 0, first_k = -1, last_k = -1, order_err = 0, stab_err = 0;
    bit held = 0;
    screen_xy_t hold_xy = '0;
    logic [2:0] hold_col = '0;
    bus.mode = m; bus.fg_color = fg; bus.bg_color = bg;
    bus.render_ack = 1'b1; bus.pix_ready = 1'b1;
    @(posedge Clk); #1;
    if (!hold) bus.render_ack = 1'b0;
    check("start_busy", bus.busy, 1);
    for (int k = 0; k < 600 && n < Pix; k++) begin
      if (bus.pix_valid && first_k < 0) first_k = k;
      if (held && (!bus.pix_valid || bus.coords_out !== hold_xy || bus.color_out !== hold_col))
        stab_err++;
      if (hold && n == 5) begin
        bus.mode = m2; bus.fg_color = fg2; bus.bg_color = bg2;
      end
      bus.pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held = bus.pix_valid && !bus.pix_ready;
      hold_xy = bus.coords_out;
      hold_col = bus.color_out;
      if (bus.pix_valid && bus.pix_ready) begin
        if (int'(bus.coords_out.x) != n % W || int'(bus.coords_out.y) != n / W) order_err++;
        frame_col[n] = bus.color_out;
        n++;
        last_k = k;
      end
      @(posedge Clk); #1;
    end
    check("beats", n, Pix);
    check("raster", order_err, 0);
    if (stall) begin
      check("stall_hold", stab_err, 0);
    end else begin
      check("first_valid_cycle", first_k + 1, 3);
      check("no_bubble", last_k - first_k, Pix - 1);
    end
    check("done_pulse", bus.render_done, 1);
    check("done_idle", bus.busy, 0);
    @(posedge Clk); #1;
    check("done_width", bus.render_done, 0);
    check("idle_gap", bus.busy, 0);
    bus.pix_ready = 1'b1;
  endtask

  initial begin
    int frames = 0;
    int err;
    int hits [SW];
    int hit_row [SW];
    int n;
    bit seen;

    Reset_n = 1'b0;
    bus.mode = '0; bus.fg_color = '0; bus.bg_color = '0;
    bus.render_ack = 1'b0; bus.pix_ready = 1'b1;
    sb.mode = '0; sb.fg_color = '0; sb.bg_color = '0;
    sb.render_ack = 1'b0; sb.pix_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk); #1;

    add(8, 5, 0, 0, 0, 5); add(8, 5, 0, 7, 3, 5); add(8, 5, 0, 3, 2, 5);
    add(1, 7, 2, 0, 0, 7); add(1, 7, 2, 1, 1, 7); add(1, 7, 2, 2, 2, 7);
    add(1, 7, 2, 3, 3, 7); add(1, 7, 2, 1, 0, 2); add(1, 7, 2, 4, 3, 2);
    add(2, 3, 4, 5, 0, 3); add(2, 3, 4, 5, 1, 4);
    add(3, 6, 1, 1, 0, 6); add(3, 6, 1, 2, 1, 6); add(3, 6, 1, 7, 3, 6); add(3, 6, 1, 2, 0, 1);
    add(4, 2, 5, 6, 2, 2); add(4, 2, 5, 6, 1, 5);
    add(5, 4, 0, 0, 1, 4); add(5, 4, 0, 1, 3, 4); add(5, 4, 0, 2, 3, 0);
    add(6, 1, 6, 7, 0, 6);
    add(7, 5, 2, 0, 2, 5); add(7, 5, 2, 1, 3, 5); add(7, 5, 2, 3, 0, 5); add(7, 5, 2, 0, 0, 2);
    add(9, 7, 0, 0, 0, 0); add(9, 7, 0, 2, 0, 7); add(9, 7, 0, 2, 2, 0); add(9, 7, 0, 3, 1, 7);
    add(12, 7, 3, 0, 0, 3); add(0, 7, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode) begin
        run_frame(vecs[i].mode, vecs[i].fg, vecs[i].bg, 0, 0, 0, 0, 0);
        frames++;
      end
      check($sformatf("mode%0d_px%0d_%0d", vecs[i].mode, vecs[i].x, vecs[i].y),
            frame_col[vecs[i].y * W + vecs[i].x], vecs[i].exp);
    end
    check("frame_count", bus.frame_count, frames);

    run_frame(1, 7, 2, 1, 0, 0, 0, 0);
    err = 0;
    for (int p = 0; p < Pix; p++) if (frame_col[p] !== ((p % W == p / W) ? 3'd7 : 3'd2)) err++;
    check("stall_frame", err, 0);

    run_frame(8, 5, 0, 0, 1, 1, 7, 2);
    err = 0;
    for (int p = 0; p < Pix; p++) if (frame_col[p] !== 3'd5) err++;
    check("held_f1_latched", err, 0);
    run_frame(1, 7, 2, 0, 1, 1, 7, 2);
    bus.render_ack = 1'b0;
    err = 0;
    for (int p = 0; p < Pix; p++) if (frame_col[p] !== ((p % W == p / W) ? 3'd7 : 3'd2)) err++;
    check("held_f2_newmode", err, 0);
    repeat (2) @(posedge Clk);
    #1 check("held_release_idle", bus.busy, 0);

    force u_dut.frame_count_q = 16'hFFFF;
    @(posedge Clk); #1;
    release u_dut.frame_count_q;
    check("fc_preload", bus.frame_count, 16'hFFFF);
    run_frame(8, 5, 0, 0, 0, 0, 0, 0);
    check("fc_wrap", bus.frame_count, 0);

    bus.mode = 4'd8; bus.fg_color = 3'd5; bus.render_ack = 1'b1;
    @(posedge Clk); #1;
    bus.render_ack = 1'b0;
    repeat (8) @(posedge Clk);
    #1 check("mid_valid", bus.pix_valid, 1);
    Reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      if (bus.render_done || bus.busy) seen = 1;
    end
    check("midrst_quiet", seen, 0);

    for (int x = 0; x < SW; x++) begin hits[x] = 0; hit_row[x] = -1; end
    sb.mode = 4'd7; sb.fg_color = 3'd1; sb.bg_color = 3'd0; sb.render_ack = 1'b1;
    @(posedge Clk); #1;
    sb.render_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 5000 && n < SW * SH; k++) begin
      if (sb.pix_valid) begin
        if (sb.color_out == 3'd1) begin
          hits[sb.coords_out.x] = hits[sb.coords_out.x] + 1;
          hit_row[sb.coords_out.x] = int'(sb.coords_out.y);
        end
        n++;
      end
      @(posedge Clk); #1;
    end
    check("sine_beats", n, SW * SH);
    for (int x = 0; x < SW; x++) begin
      int a, v, row;
      a = (x * 16) % 64;
      v = int'(16.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 64.0));
      row = ((v + 16) * (SH / 2)) / 16;
      if (row > SH - 1) row = SH - 1;
      check($sformatf("sine_hits_col%0d", x), hits[x], 1);
      check($sformatf("sine_row_col%0d", x), hit_row[x], row);
    end
    check("sine_peak_row", hit_row[1], SH - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
